instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch-side initiator for the single-cycle instruction ROM (word-addressed, combinational read).
//  - Owns the PC, drives the ROM address and captures the returned word into a 1-entry output register.
//  - Hands instructions to decode with a valid/ready handshake.
//  - Supports redirect (branch/jump) and a halt word that stops fetching.
// PARAMETERS
//  ADDR_W     8             ROM word-address width (PC width)
//  DATA_W     32            instruction width
//  RESET_PC   8'h00         PC value loaded on reset
//  HALT_WORD  32'hFFFF_FFFF instruction encoding that stops fetch
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       asynchronous active-low reset
//  imem_addr       out  ADDR_W  word address to ROM; equals PC, combinational from PC register
//  imem_rd         in   DATA_W  ROM read data for imem_addr, same cycle
//  redirect_valid  in   1       load redirect_pc into PC this cycle
//  redirect_pc     in   ADDR_W  redirect target (word address)
//  instr_valid     out  1       output register holds a valid instruction
//  instr           out  DATA_W  fetched instruction
//  instr_pc        out  ADDR_W  word address instr was fetched from
//  instr_ready     in   1       decode accepts instr when instr_valid & instr_ready
//  halted          out  1       fetch stopped on HALT_WORD
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//      PC=RESET_PC, state=IDLE, instr_valid=0, instr=0, instr_pc=0, halted=0.
//  - States:
//      IDLE: first cycle after reset release; no fetch; next=RUN.
//      RUN:  fetch active.
//      HALT: fetch stopped; halted=1.
//  - Load condition in RUN: load = !instr_valid | instr_ready.
//      On load: instr<=imem_rd, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
//      PC+1 wraps modulo 2^ADDR_W (8'hFF -> 8'h00, no flag).
//  - Stall: in RUN with instr_valid=1 and instr_ready=0, PC, instr, instr_pc and instr_valid all hold.
//  - Latency: an instruction appears on instr one cycle after its address is driven on imem_addr.
//      Sustained throughput is 1 per cycle while instr_ready=1.
//  - Halt: on load, if imem_rd==HALT_WORD:
//      - the halt word is still presented (instr_valid=1) and PC does not advance;
//      - next state=HALT;
//      - in HALT no further loads occur; instr_valid clears once the halt word is accepted.
//  - Redirect has top priority, in any state except IDLE:
//      - PC<=redirect_pc and instr_valid<=0 (held word discarded, even if instr_ready=1 that cycle);
//      - state<=RUN and halted<=0;
//      - no load that cycle.
//  - Redirect during IDLE is ignored.
//  - Reset mid-operation: immediate return to reset values, in-flight word dropped.
//  - imem_addr is never X after reset; no combinational path from instr_ready to imem_addr.
// CONFIGURATION
//  IFU_FETCH_COUNT_EN defined:
//    - adds port fetch_count (out, 16): counts handshakes (instr_valid & instr_ready);
//    - saturates at 16'hFFFF; reset 0; not cleared by redirect.
//  IFU_FETCH_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. ROM 0:0x20080005, 1:0x20090003, 2:0x01095020, ready=1, release reset:
//     instr_pc 0,1,2 on consecutive cycles starting 2 cycles after release; instr matches ROM.
//  2. Hold ready=0 for 3 cycles with instr_pc=1 valid:
//     imem_addr stays 2; instr/instr_pc stable; ready=1 -> next instr_pc=2.
//  3. Redirect to 8'h40 while instr_pc=5 valid and ready=0:
//     next cycle instr_valid=0, imem_addr=8'h40; following cycle instr_pc=8'h40.
//  4. ROM[3]=32'hFFFF_FFFF:
//     halt word presented with instr_pc=3, halted=1, imem_addr stays 3;
//     after acceptance instr_valid=0; redirect to 0 clears halted and resumes fetch.
//  5. Redirect to 8'hFE, ready=1:
//     instr_pc sequence FE, FF, 00, 01 (wrap).
//  6. Assert rst_n=0 mid-stream with instr_valid=1:
//     instr_valid=0, imem_addr=RESET_PC immediately; IFU_FETCH_COUNT_EN build: fetch_count=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational ROM and holds one fetched word for decode.
// Optional handshake counter port enabled by defining IFU_FETCH_COUNT_EN.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              halted
`ifdef IFU_FETCH_COUNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } ireg_t;

    state_t            state, state_nxt;
    ireg_t             ireg;
    logic [ADDR_W-1:0] pc;
    logic              fetch_en, redir_en;
    logic              redir, load, is_halt;

    assign imem_addr   = pc;
    assign instr_valid = ireg.vld;
    assign instr       = ireg.word;
    assign instr_pc    = ireg.pc;

    // Redirect beats everything; a load needs room in the output register.
    assign is_halt = (imem_rd == HALT_WORD);
    assign redir   = redirect_valid && redir_en;
    assign load    = fetch_en && !redir && (!ireg.vld || instr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN: begin
                if (redir)                state_nxt = RUN;
                else if (load && is_halt) state_nxt = HALT;
            end
            HALT:    if (redir) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        halted   = 1'b0;
        fetch_en = 1'b0;
        redir_en = 1'b0;
        case (state)
            RUN: begin
                fetch_en = 1'b1;
                redir_en = 1'b1;
            end
            HALT: begin
                halted   = 1'b1;
                redir_en = 1'b1;
            end
            default: ;
        endcase
    end

    // The halt word does not advance the PC, so imem_addr keeps pointing at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                pc <= RESET_PC;
        else if (redir)            pc <= redirect_pc;
        else if (load && !is_halt) pc <= pc + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ireg <= '0;
        end else if (redir) begin
            ireg.vld <= 1'b0;
        end else if (load) begin
            ireg.vld  <= 1'b1;
            ireg.pc   <= pc;
            ireg.word <= imem_rd;
        end else if (halted && ireg.vld && instr_ready) begin
            ireg.vld <= 1'b0;
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_count <= '0;
        else if (ireg.vld && instr_ready && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
    end
`endif

endmodule
